ctr20_core: RTL and testbench

//  Mod-20 seconds counter that produces the 5-bit state (0..19) consumed by the
//  two-digit seven-segment decoder stage. It divides the board clock to a count

---
 rtl/ctr20_pkg.sv | 10 +
 rtl/ctr20_key_press.sv | 37 +++
 rtl/ctr20_core.sv | 99 +++++++++
 tb/tb_ctr20_core.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr20_pkg.sv
// Shared constants and state type for the mod-20 seconds counter
// and the seven-segment decoder stage that consumes its state.
package ctr20_pkg;
    localparam int MAXV = 19;
    localparam int W    = 5;

    typedef logic [W-1:0] state_t;

    localparam state_t MAXV_S = state_t'(MAXV);
endpackage

// File: rtl/ctr20_key_press.sv
// Raw active-low key to one-cycle press pulse: 2-flop synchroniser,
// edge register and a registered falling-edge pulse.
module key_press (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    logic [1:0] sync_q, sync_d;
    logic       lvl_q, lvl_d;
    logic [2:0] arm_q, arm_d;
    logic       press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        lvl_d   = sync_q[1];
        arm_d   = {arm_q[1:0], 1'b1};
        // Keys still held when reset drops must not look like fresh presses.
        press_d = arm_q[2] & lvl_q & ~sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            lvl_q   <= 1'b1;
            arm_q   <= 3'b000;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            lvl_q   <= lvl_d;
            arm_q   <= arm_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/ctr20_core.sv
// Mod-20 up/down seconds counter with prescaler, run/stop and clear keys.
// MAXV and W come from ctr20_pkg so the decoder stage sees the same range.
module ctr20_core
    import ctr20_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_run_n,
    input  logic         key_clr_n,
    input  logic         up,
    output logic [W-1:0] state,
    output logic         run,
    output logic         tick,
    output logic         wrap
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic          run_press;
    logic          clr_press;
    logic [PW-1:0] pre_q, pre_d;
    logic          run_q, run_d;
    state_t        state_q, state_d;
    logic          wrap_q, wrap_d;

    key_press u_key_run (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_press u_key_clr (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clr_n),
        .press (clr_press)
    );

    always_comb begin
        tick    = run_q && (pre_q == PRE_MAX);
        run_d   = run_q ^ run_press;
        pre_d   = pre_q;
        state_d = state_q;
        wrap_d  = 1'b0;

        // Prescaler holds while paused so a resume keeps the tick phase.
        if (run_q) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        if (tick) begin
            if (state_q > MAXV_S) begin
                state_d = '0;
            end else if (up) begin
                if (state_q == MAXV_S) begin
                    state_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = state_q + state_t'(1);
                end
            end else begin
                if (state_q == '0) begin
                    state_d = MAXV_S;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = state_q - state_t'(1);
                end
            end
        end

        // Clear overrides a coincident count step; run is left alone.
        if (clr_press) begin
            state_d = '0;
            pre_d   = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            run_q   <= 1'b0;
            state_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            run_q   <= run_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign state = state_q;
    assign run   = run_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_ctr20_core.sv
// Randomised and directed bench for ctr20_core against a cycle model.
module tb_ctr20_core;
    import ctr20_pkg::*;

    localparam int DIV = 4;

    logic         clk;
    logic         rst;
    logic         key_run_n;
    logic         key_clr_n;
    logic         up;
    logic [W-1:0] state;
    logic         run;
    logic         tick;
    logic         wrap;

    int n_total = 0;
    int n_bad   = 0;

    int m_state;
    int m_pre;
    bit m_run;
    bit m_wrap;
    bit hr[4];
    bit hc[4];

    ctr20_core #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_run_n (key_run_n),
        .key_clr_n (key_clr_n),
        .up        (up),
        .state     (state),
        .run       (run),
        .tick      (tick),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_tick();
        return m_run && (m_pre == DIV - 1);
    endfunction

    function automatic logic [7:0] exp_vec();
        return {5'(m_state), m_run, m_tick(), m_wrap};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {state, run, tick, wrap};
    endfunction

    // Advance the reference model by one edge, then clock the DUT.
    // A press applies 3 edges after the key is first seen low, and only
    // when it was seen released (after reset) on the edge before that.
    task automatic cyc();
        bit rp, cp, tk;
        if (rst) begin
            m_state = 0;
            m_pre   = 0;
            m_run   = 0;
            m_wrap  = 0;
            for (int i = 0; i < 4; i++) begin
                hr[i] = 0;
                hc[i] = 0;
            end
        end else begin
            rp = !hr[2] && hr[3];
            cp = !hc[2] && hc[3];
            tk = m_tick();
            m_wrap = 0;
            if (cp) begin
                m_state = 0;
                m_pre   = 0;
            end else begin
                if (m_run) m_pre = (m_pre + 1) % DIV;
                if (tk) begin
                    if (up) begin
                        m_wrap  = (m_state == MAXV);
                        m_state = (m_state + 1) % (MAXV + 1);
                    end else begin
                        m_wrap  = (m_state == 0);
                        m_state = (m_state + MAXV) % (MAXV + 1);
                    end
                end
            end
            m_run = m_run ^ rp;
            for (int i = 3; i > 0; i--) begin
                hr[i] = hr[i-1];
                hc[i] = hc[i-1];
            end
            hr[0] = key_run_n;
            hc[0] = key_clr_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        key_run_n = 1;
        key_clr_n = 1;
        up = 1;
        repeat (3) cyc();
        n_total++;
        if (obs_vec() !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), 8'h00);
        end
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            n_total++;
            if (obs_vec() !== 8'h00) begin
                n_bad++;
                $display("FAIL idle_hold cyc=%0d got=%h exp=00", i, obs_vec());
            end
        end
    endtask

    task automatic test_count_up();
        int wraps;
        int top;
        up = 1;
        key_run_n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++;
            if (run !== 1'b0) begin
                n_bad++;
                $display("FAIL run_latency_early k+%0d got=%b exp=0", i, run);
            end
        end
        cyc();
        n_total++;
        if (run !== 1'b1) begin
            n_bad++;
            $display("FAIL run_latency k+3 got=%b exp=1", run);
        end
        wraps = 0;
        top = 0;
        for (int i = 0; i < 90; i++) begin
            if (i == 6) key_run_n = 1;
            cyc();
            n_total++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL count_up cyc=%0d got=%h exp=%h",
                         i, obs_vec(), exp_vec());
            end
            if (wrap === 1'b1) begin
                wraps++;
                n_total++;
                if (state !== '0) begin
                    n_bad++;
                    $display("FAIL wrap_up_state got=%0d exp=0", state);
                end
            end
            if (int'(state) > top) top = int'(state);
        end
        n_total++;
        if (wraps != 1 || top != MAXV) begin
            n_bad++;
            $display("FAIL up_sweep wraps=%0d top=%0d exp wraps=1 top=%0d",
                     wraps, top, MAXV);
        end
    endtask

    task automatic wait_tick();
        bit t;
        for (int i = 0; i < 2 * DIV; i++) begin
            t = m_tick();
            cyc();
            n_total++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL tick_wait got=%h exp=%h", obs_vec(), exp_vec());
            end
            if (t) break;
        end
    endtask

    task automatic test_count_down();
        key_clr_n = 0;
        cyc();
        key_clr_n = 1;
        repeat (3) cyc();
        up = 0;
        wait_tick();
        n_total++;
        if (state !== 5'(MAXV) || wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL down_wrap got state=%0d wrap=%b exp %0d/1",
                     state, wrap, MAXV);
        end
        wait_tick();
        n_total++;
        if (state !== 5'(MAXV - 1) || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL down_step got state=%0d wrap=%b exp %0d/0",
                     state, wrap, MAXV - 1);
        end
        cyc();
        up = 1;
        wait_tick();
        n_total++;
        if (state !== 5'(MAXV) || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL dir_change got state=%0d wrap=%b exp %0d/0",
                     state, wrap, MAXV);
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] st;
        for (int i = 0; i < 3 * DIV && m_pre != 2; i++) cyc();
        n_total++;
        if (m_pre != 2 || !m_run) begin
            n_bad++;
            $display("FAIL pause_setup got pre=%0d exp=2", m_pre);
        end
        key_run_n = 0;
        repeat (4) cyc();
        key_run_n = 1;
        st = state;
        n_total++;
        if (obs_vec() !== exp_vec() || run !== 1'b0) begin
            n_bad++;
            $display("FAIL pause got=%h exp=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_total++;
            if (state !== st || tick !== 1'b0 || run !== 1'b0) begin
                n_bad++;
                $display("FAIL frozen cyc=%0d got st=%0d tk=%b exp st=%0d tk=0",
                         i, state, tick, st);
            end
        end
        key_run_n = 0;
        repeat (4) cyc();
        key_run_n = 1;
        n_total++;
        if (run !== 1'b1 || tick !== 1'b0) begin
            n_bad++;
            $display("FAIL resume got run=%b tick=%b exp 1/0", run, tick);
        end
        cyc();
        n_total++;
        if (tick !== 1'b1 || state !== st) begin
            n_bad++;
            $display("FAIL resume_phase got tick=%b st=%0d exp 1/%0d",
                     tick, state, st);
        end
    endtask

    task automatic test_clear();
        int ticks;
        up = 1;
        for (int i = 0; i < 200 && !(m_state == 7 && m_pre == 0); i++) cyc();
        n_total++;
        if (!(m_state == 7 && m_pre == 0)) begin
            n_bad++;
            $display("FAIL clear_setup got st=%0d pre=%0d exp 7/0",
                     m_state, m_pre);
        end
        key_clr_n = 0;
        repeat (3) cyc();
        n_total++;
        if (tick !== 1'b1 || state !== 5'd7) begin
            n_bad++;
            $display("FAIL clear_align got tick=%b st=%0d exp 1/7", tick, state);
        end
        cyc();
        n_total++;
        if (state !== '0 || wrap !== 1'b0 || run !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_tick got st=%0d wrap=%b run=%b exp 0/0/1",
                     state, wrap, run);
        end
        ticks = 0;
        for (int i = 0; i < 17; i++) begin
            if (tick === 1'b1) ticks++;
            cyc();
            n_total++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_hold cyc=%0d got=%h exp=%h",
                         i, obs_vec(), exp_vec());
            end
        end
        key_clr_n = 1;
        n_total++;
        if (int'(state) != ticks || ticks == 0) begin
            n_bad++;
            $display("FAIL single_clear got st=%0d exp=%0d", state, ticks);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 400 && !(m_state == 13 && m_run); i++) cyc();
        n_total++;
        if (!(m_state == 13 && m_run)) begin
            n_bad++;
            $display("FAIL rst_setup got st=%0d exp=13", m_state);
        end
        key_run_n = 0;
        rst = 1;
        cyc();
        rst = 0;
        n_total++;
        if (obs_vec() !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_mid got=%h exp=00", obs_vec());
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) key_run_n = 1;
            cyc();
            n_total++;
            if (obs_vec() !== 8'h00) begin
                n_bad++;
                $display("FAIL held_key cyc=%0d got=%h exp=00", i, obs_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) key_run_n = ~key_run_n;
            if ($urandom_range(39) == 0) key_clr_n = ~key_clr_n;
            if ($urandom_range(29) == 0) up = ~up;
            cyc();
            n_total++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1;
        key_run_n = 1;
        key_clr_n = 1;
        up = 1;
        test_reset();
        test_count_up();
        test_count_down();
        test_pause();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
